// File: rtl/irq_controller_pkg.sv
// -----------------------------------------------------------------------------
// irq_controller_pkg
// Shared definitions for the interrupt front-end:
//   - irq_state_e : request FSM state encodings (IDLE / REQ / HOLD)
//   - IRQ_STAT_W  : width of the optional per-source acknowledge counters
//   - IRQ_HOLD_W  : width of the hold-off down-counter (HOLDOFF <= 255)
//   - sat_inc     : saturating increment used by the acknowledge counters
// -----------------------------------------------------------------------------
package irq_controller_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_HOLD = 2'd2
  } irq_state_e;

  localparam int IRQ_STAT_W = 16;
  localparam int IRQ_HOLD_W = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [IRQ_STAT_W-1:0] sat_inc(input logic [IRQ_STAT_W-1:0] v);
    return (v == {IRQ_STAT_W{1'b1}}) ? v : (v + IRQ_STAT_W'(1));
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// -----------------------------------------------------------------------------
// irq_controller_if
// Bundles the request lines, mask write port, core handshake and status of the
// interrupt front-end.
//   irq_in      : raw asynchronous request lines           (master -> slave)
//   mask_we     : mask register write strobe               (master -> slave)
//   mask_din    : new mask value, bit=1 enables a source   (master -> slave)
//   int_ack     : one-cycle acknowledge from the core      (master -> slave)
//   interrupter : request to the core                      (slave -> master)
//   int_cause   : index of the presented source            (slave -> master)
//   pending     : raw pending bits                         (slave -> master)
// With IRQ_STATS_EN defined the interface also carries:
//   stat_sel    : counter select                           (master -> slave)
//   stat_cnt    : registered acknowledge count             (slave -> master)
// -----------------------------------------------------------------------------
interface irq_controller_if #(
  parameter int NSRC = 2,
  parameter int ID_W = 1
);
  import irq_controller_pkg::*;

  logic [NSRC-1:0] irq_in;
  logic            mask_we;
  logic [NSRC-1:0] mask_din;
  logic            int_ack;
  logic            interrupter;
  logic [ID_W-1:0] int_cause;
  logic [NSRC-1:0] pending;
`ifdef IRQ_STATS_EN
  logic [ID_W-1:0]       stat_sel;
  logic [IRQ_STAT_W-1:0] stat_cnt;
`endif

  modport master (
    output irq_in, mask_we, mask_din, int_ack,
`ifdef IRQ_STATS_EN
    output stat_sel,
    input  stat_cnt,
`endif
    input  interrupter, int_cause, pending
  );

  modport slave (
    input  irq_in, mask_we, mask_din, int_ack,
`ifdef IRQ_STATS_EN
    input  stat_sel,
    output stat_cnt,
`endif
    output interrupter, int_cause, pending
  );

endinterface

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// Two-flop synchroniser for one asynchronous request line followed by a
// registered copy used to detect a synchronised rising edge.
//   clk     : core clock
//   rst     : asynchronous active-low reset
//   i_async : raw request line
//   o_level : synchronised level
//   o_rise  : high for one cycle after a synchronised 0->1 transition
// -----------------------------------------------------------------------------
module irq_sync_edge
  import irq_controller_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchroniser chain plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Interrupt front-end in front of the CPU core. Synchronises NSRC external
// request lines, latches them as pending, masks them, picks the lowest-index
// enabled source and presents it to the core until acknowledged, then waits
// HOLDOFF cycles before presenting the next one.
//   clk  : core clock
//   rst  : asynchronous active-low reset
//   bus  : irq_controller_if.slave (request lines, mask port, core handshake,
//          pending status)
// Optional feature macro: IRQ_STATS_EN adds per-source 16-bit saturating
// acknowledge counters readable through bus.stat_sel / bus.stat_cnt.
// -----------------------------------------------------------------------------
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int              NSRC      = 2,
  parameter int              ID_W      = 1,
  parameter logic [NSRC-1:0] EDGE_MASK = {NSRC{1'b1}},
  parameter int              HOLDOFF   = 4
) (
  input logic             clk,
  input logic             rst,
  irq_controller_if.slave bus
);

  logic [NSRC-1:0]       w_level;
  logic [NSRC-1:0]       w_rise;
  logic [NSRC-1:0]       w_set;
  logic [NSRC-1:0]       w_clr;
  logic [NSRC-1:0]       w_pend_nxt;
  logic [NSRC-1:0]       w_masked;
  logic                  w_any;
  logic [ID_W-1:0]       w_idx;
  logic                  w_ack_take;

  logic [NSRC-1:0]       r_pending;
  logic [NSRC-1:0]       r_mask;
  irq_state_e            r_state;
  logic [IRQ_HOLD_W-1:0] r_cnt;
  logic                  r_irq;
  logic [ID_W-1:0]       r_cause;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (bus.irq_in[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  // An acknowledge only counts while a request is actually being presented.
  assign w_ack_take = (r_state == IRQ_REQ) && bus.int_ack;

  // Next pending value: set terms are ORed in after the clear, so a set in
  // the acknowledge cycle keeps the bit high.
  always_comb begin
    w_set = (EDGE_MASK & w_rise) | (~EDGE_MASK & w_level);
    if (w_ack_take) begin
      w_clr = NSRC'(1) << r_cause;
    end else begin
      w_clr = {NSRC{1'b0}};
    end
    w_pend_nxt = (r_pending & ~w_clr) | w_set;
  end

  // Fixed-priority encoder: scanning downwards leaves the lowest index last.
  always_comb begin
    w_masked = r_pending & r_mask;
    w_any    = 1'b0;
    w_idx    = {ID_W{1'b0}};
    for (int i = NSRC - 1; i >= 0; i--) begin
      w_any = w_any | w_masked[i];
      w_idx = w_masked[i] ? ID_W'(i) : w_idx;
    end
  end

  // Pending latch and mask register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= {NSRC{1'b0}};
      r_mask    <= {NSRC{1'b1}};
    end else begin
      r_pending <= w_pend_nxt;
      if (bus.mask_we) begin
        r_mask <= bus.mask_din;
      end else begin
        r_mask <= r_mask;
      end
    end
  end

  // Request FSM; int_cause is only reloaded on entry to REQ so it keeps its
  // last value in HOLD and IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IRQ_IDLE;
      r_cnt   <= {IRQ_HOLD_W{1'b0}};
      r_irq   <= 1'b0;
      r_cause <= {ID_W{1'b0}};
    end else begin
      case (r_state)
        IRQ_IDLE: begin
          if (w_any) begin
            r_cause <= w_idx;
            r_irq   <= 1'b1;
            r_state <= IRQ_REQ;
          end else begin
            r_irq   <= 1'b0;
          end
        end
        IRQ_REQ: begin
          if (bus.int_ack) begin
            r_irq   <= 1'b0;
            r_cnt   <= IRQ_HOLD_W'(HOLDOFF);
            r_state <= IRQ_HOLD;
          end else begin
            r_irq   <= 1'b1;
          end
        end
        IRQ_HOLD: begin
          r_irq <= 1'b0;
          // Leaving on the step that reaches zero gives 1+HOLDOFF low cycles.
          if (r_cnt <= IRQ_HOLD_W'(1)) begin
            r_cnt   <= {IRQ_HOLD_W{1'b0}};
            r_state <= IRQ_IDLE;
          end else begin
            r_cnt   <= r_cnt - IRQ_HOLD_W'(1);
          end
        end
        default: begin
          r_irq   <= 1'b0;
          r_cnt   <= {IRQ_HOLD_W{1'b0}};
          r_state <= IRQ_IDLE;
        end
      endcase
    end
  end

  assign bus.interrupter = r_irq;
  assign bus.int_cause   = r_cause;
  assign bus.pending     = r_pending;

`ifdef IRQ_STATS_EN
  logic [IRQ_STAT_W-1:0] r_stat [NSRC];
  logic [IRQ_STAT_W-1:0] r_stat_cnt;

  // Per-source acknowledge counters and the registered read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSRC; i++) begin
        r_stat[i] <= {IRQ_STAT_W{1'b0}};
      end
      r_stat_cnt <= {IRQ_STAT_W{1'b0}};
    end else begin
      if (w_ack_take) begin
        r_stat[r_cause] <= sat_inc(r_stat[r_cause]);
      end else begin
        r_stat[r_cause] <= r_stat[r_cause];
      end
      // Selects beyond NSRC (non power-of-two source counts) read as zero.
      if (int'(bus.stat_sel) < NSRC) begin
        r_stat_cnt <= r_stat[bus.stat_sel];
      end else begin
        r_stat_cnt <= {IRQ_STAT_W{1'b0}};
      end
    end
  end

  assign bus.stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
// Self-checking bench for irq_controller. One instance uses edge-triggered
// sources on both lines, a second uses a level-triggered source 0. A cycle
// table drives the edge instance; each row's expected outputs are queued when
// the row is driven and compared once the clock edge has produced them.
// Hand-written sequences cover the level-source re-presentation gap and an
// asynchronous reset in the middle of a request. Honours IRQ_STATS_EN.
// -----------------------------------------------------------------------------
module tb_irq_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  irq_controller_if #(.NSRC(2), .ID_W(1)) bus_e ();
  irq_controller_if #(.NSRC(2), .ID_W(1)) bus_l ();

  irq_controller #(.NSRC(2), .ID_W(1), .EDGE_MASK(2'b11), .HOLDOFF(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_e)
  );

  irq_controller #(.NSRC(2), .ID_W(1), .EDGE_MASK(2'b10), .HOLDOFF(4)) dut_lvl (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  typedef struct {
    logic [1:0] irq;
    logic       mwe;
    logic [1:0] mdin;
    logic       ack;
    logic       e_irq;
    logic       e_cause;
    logic [1:0] e_pend;
  } vec_t;

  typedef struct {
    int         idx;
    logic       e_irq;
    logic       e_cause;
    logic [1:0] e_pend;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] irq, input logic mwe, input logic [1:0] mdin,
                     input logic ack, input logic e_irq, input logic e_cause,
                     input logic [1:0] e_pend);
    vec_t v;
    v.irq = irq; v.mwe = mwe; v.mdin = mdin; v.ack = ack;
    v.e_irq = e_irq; v.e_cause = e_cause; v.e_pend = e_pend;
    vq.push_back(v);
  endtask

  // Counts clock edges until the chosen instance raises interrupter (max 40).
  task automatic wait_high(input bit lvl, output int cycles);
    cycles = 0;
    while (((lvl ? bus_l.interrupter : bus_e.interrupter) == 1'b0) && (cycles < 40)) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;

    bus_e.irq_in = 2'b00; bus_e.mask_we = 1'b0; bus_e.mask_din = 2'b11; bus_e.int_ack = 1'b0;
    bus_l.irq_in = 2'b00; bus_l.mask_we = 1'b0; bus_l.mask_din = 2'b11; bus_l.int_ack = 1'b0;
`ifdef IRQ_STATS_EN
    bus_e.stat_sel = 1'b0;
    bus_l.stat_sel = 1'b0;
`endif

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset interrupter", 32'(bus_e.interrupter), 32'd0);
    chk("reset int_cause",   32'(bus_e.int_cause),   32'd0);
    chk("reset pending",     32'(bus_e.pending),     32'd0);
    chk("reset lvl pending", 32'(bus_l.pending),     32'd0);
`ifdef IRQ_STATS_EN
    chk("reset stat_cnt",    32'(bus_e.stat_cnt),    32'd0);
`endif
    rst = 1'b1;

    // ---- cycle table: irq, mwe, mdin, ack | interrupter, int_cause, pending ----
    // irq_in[1] held 3 cycles, presented 4 edges later, held until ack
    add(2'b00,0,2'b11,0, 0,0,2'b00);
    add(2'b10,0,2'b11,0, 0,0,2'b00);
    add(2'b10,0,2'b11,0, 0,0,2'b00);
    add(2'b10,0,2'b11,0, 0,0,2'b10);
    add(2'b00,0,2'b11,0, 1,1,2'b10);
    add(2'b00,0,2'b11,0, 1,1,2'b10);
    add(2'b00,0,2'b11,1, 0,1,2'b00);
    add(2'b00,0,2'b11,0, 0,1,2'b00);
    add(2'b00,0,2'b11,1, 0,1,2'b00);   // ack in HOLD ignored
    add(2'b00,0,2'b11,0, 0,1,2'b00);
    add(2'b00,0,2'b11,0, 0,1,2'b00);
    add(2'b00,0,2'b11,0, 0,1,2'b00);
    // both sources rise together: 0 first, 1 after ack + hold-off
    add(2'b11,0,2'b11,0, 0,1,2'b00);
    add(2'b11,0,2'b11,0, 0,1,2'b00);
    add(2'b11,0,2'b11,0, 0,1,2'b11);
    add(2'b11,0,2'b11,0, 1,0,2'b11);
    add(2'b11,0,2'b11,1, 0,0,2'b10);
    for (int k = 0; k < 4; k++) add(2'b11,0,2'b11,0, 0,0,2'b10);
    add(2'b11,0,2'b11,0, 1,1,2'b10);
    add(2'b00,0,2'b11,1, 0,1,2'b00);
    for (int k = 0; k < 4; k++) add(2'b00,0,2'b11,0, 0,1,2'b00);
    // masked source records pending but is presented only after unmask
    add(2'b00,1,2'b10,0, 0,1,2'b00);
    add(2'b01,0,2'b10,0, 0,1,2'b00);
    add(2'b01,0,2'b10,0, 0,1,2'b00);
    add(2'b01,0,2'b10,0, 0,1,2'b01);
    add(2'b01,0,2'b10,0, 0,1,2'b01);
    add(2'b01,0,2'b10,0, 0,1,2'b01);
    add(2'b00,1,2'b11,0, 0,1,2'b01);
    add(2'b00,0,2'b11,0, 1,0,2'b01);
    add(2'b00,0,2'b11,1, 0,0,2'b00);
    for (int k = 0; k < 4; k++) add(2'b00,0,2'b11,0, 0,0,2'b00);
    // new edge on the acked source lands in the ack cycle: set wins
    add(2'b10,0,2'b11,0, 0,0,2'b00);
    add(2'b10,0,2'b11,0, 0,0,2'b00);
    add(2'b10,0,2'b11,0, 0,0,2'b10);
    add(2'b00,0,2'b11,0, 1,1,2'b10);
    add(2'b00,0,2'b11,0, 1,1,2'b10);
    add(2'b10,0,2'b11,0, 1,1,2'b10);
    add(2'b10,0,2'b11,0, 1,1,2'b10);
    add(2'b10,0,2'b11,1, 0,1,2'b10);
    for (int k = 0; k < 4; k++) add(2'b10,0,2'b11,0, 0,1,2'b10);
    add(2'b00,0,2'b11,0, 1,1,2'b10);
    add(2'b00,0,2'b11,1, 0,1,2'b00);
    for (int k = 0; k < 4; k++) add(2'b00,0,2'b11,0, 0,1,2'b00);

    for (int i = 0; i < vq.size(); i++) begin
      bus_e.irq_in   = vq[i].irq;
      bus_e.mask_we  = vq[i].mwe;
      bus_e.mask_din = vq[i].mdin;
      bus_e.int_ack  = vq[i].ack;
      e.idx = i; e.e_irq = vq[i].e_irq; e.e_cause = vq[i].e_cause; e.e_pend = vq[i].e_pend;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d interrupter", e.idx), 32'(bus_e.interrupter), 32'(e.e_irq));
      if (e.e_irq) begin
        chk($sformatf("vec%0d int_cause", e.idx), 32'(bus_e.int_cause), 32'(e.e_cause));
      end else begin
        chk($sformatf("vec%0d held int_cause", e.idx), 32'(bus_e.int_cause), 32'(e.e_cause));
      end
      chk($sformatf("vec%0d pending", e.idx), 32'(bus_e.pending), 32'(e.e_pend));
    end
    bus_e.mask_we = 1'b0;
    bus_e.int_ack = 1'b0;

`ifdef IRQ_STATS_EN
    // source 0 acked twice, source 1 four times (HOLD ack not counted)
    bus_e.stat_sel = 1'b0;
    @(posedge clk); #1;
    chk("stat src0", 32'(bus_e.stat_cnt), 32'd2);
    bus_e.stat_sel = 1'b1;
    @(posedge clk); #1;
    chk("stat src1", 32'(bus_e.stat_cnt), 32'd4);
`endif

    // ---- level source held high, acked twice ----
    bus_l.irq_in = 2'b01;
    wait_high(1'b1, n);
    chk("lvl latency", 32'(n), 32'd4);
    chk("lvl cause", 32'(bus_l.int_cause), 32'd0);
    for (int k = 0; k < 2; k++) begin
      bus_l.int_ack = 1'b1;
      @(posedge clk); #1;
      bus_l.int_ack = 1'b0;
      chk($sformatf("lvl%0d pending kept", k), 32'(bus_l.pending[0]), 32'd1);
      chk($sformatf("lvl%0d dropped", k), 32'(bus_l.interrupter), 32'd0);
      wait_high(1'b1, n);
      chk($sformatf("lvl%0d low gap", k), 32'(n), 32'd5);
      chk($sformatf("lvl%0d cause", k), 32'(bus_l.int_cause), 32'd0);
    end
    bus_l.irq_in = 2'b00;

    // ---- asynchronous reset while in REQ ----
    bus_e.irq_in = 2'b10;
    wait_high(1'b0, n);
    chk("pre-reset latency", 32'(n), 32'd4);
    chk("pre-reset cause", 32'(bus_e.int_cause), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst interrupter", 32'(bus_e.interrupter), 32'd0);
    chk("async rst pending",     32'(bus_e.pending),     32'd0);
    chk("async rst int_cause",   32'(bus_e.int_cause),   32'd0);
`ifdef IRQ_STATS_EN
    chk("async rst stat_cnt",    32'(bus_e.stat_cnt),    32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    // irq_in[1] is still high, so the cleared synchroniser sees a fresh edge
    wait_high(1'b0, n);
    chk("post-reset latency", 32'(n), 32'd4);
    chk("post-reset cause", 32'(bus_e.int_cause), 32'd1);
    bus_e.int_ack = 1'b1;
    @(posedge clk); #1;
    bus_e.int_ack = 1'b0;
    chk("post-reset ack clears", 32'(bus_e.pending), 32'd0);
    @(posedge clk); #1;
`ifdef IRQ_STATS_EN
    chk("post-reset stat src1", 32'(bus_e.stat_cnt), 32'd1);
`endif
    chk("post-reset hold", 32'(bus_e.interrupter), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
